tone_period_meter: RTL

Measures the half period of an incoming square-wave tone, the receive-side counterpart of the tone generator that toggles its output every `half_period` clocks. It synchronises the input, counts clock cycles between consecutive edges of either polarity, and reports each interval. It flags lock when the interval is stable and flags loss of signal when edges stop. The block sits between the audio/tone input pin and the note-recognition logic.

---
 rtl/tone_period_meter.sv | 114 +++++++++++
 1 files changed

// File: rtl/tone_period_meter.sv
// Half-period meter for a square-wave tone. It counts clocks between input edges
// and reports each interval, together with lock and loss-of-signal flags.
//   state | meaning
//   IDLE  | no tone present, waiting for a first edge
//   ARMED | one edge seen, the next edge gives the first interval
//   TRACK | measuring on every edge and comparing with the previous interval
module tone_period_meter #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 50_000_000,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sound_in,
  output logic [WIDTH-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             no_signal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] TOL_W     = WIDTH'(TOL);
  localparam logic [MW-1:0]    LOCK_W    = MW'(LOCK_COUNT);

  logic             sync1, sync2, sync3;
  logic             edge_det;
  logic             timeout;
  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] prev, prev_nx;
  logic [WIDTH-1:0] half_nx;
  logic [WIDTH-1:0] diff;
  logic [MW-1:0]    match_cnt, match_nx;
  logic             valid_nx;

  assign edge_det = sync2 ^ sync3;
  assign timeout  = (cnt == TIMEOUT_W);
  assign diff     = (cnt >= prev) ? (cnt - prev) : (prev - cnt);

  always_comb begin
    state_nx = state;
    half_nx  = half_period;
    valid_nx = 1'b0;
    prev_nx  = prev;
    match_nx = match_cnt;
    if (timeout) begin
      // An edge landing in the timeout cycle starts a fresh acquisition.
      state_nx = edge_det ? S_ARMED : S_IDLE;
      half_nx  = '0;
      match_nx = '0;
    end else if (edge_det) begin
      case (state)
        S_IDLE: state_nx = S_ARMED;
        S_ARMED: begin
          half_nx  = cnt;
          valid_nx = 1'b1;
          prev_nx  = cnt;
          match_nx = '0;
          state_nx = S_TRACK;
        end
        S_TRACK: begin
          half_nx  = cnt;
          valid_nx = 1'b1;
          prev_nx  = cnt;
          if (diff <= TOL_W) begin
            if (match_cnt != LOCK_W) match_nx = match_cnt + MW'(1);
          end else begin
            match_nx = '0;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      cnt         <= '0;
      state       <= S_IDLE;
      prev        <= '0;
      match_cnt   <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      no_signal   <= 1'b1;
    end else begin
      sync1 <= sound_in;
      sync2 <= sync1;
      sync3 <= sync2;
      // Restarting at 1 makes the count seen on the next edge equal the interval.
      if (edge_det)
        cnt <= WIDTH'(1);
      else if (!timeout)
        cnt <= cnt + WIDTH'(1);
      state       <= state_nx;
      prev        <= prev_nx;
      match_cnt   <= match_nx;
      half_period <= half_nx;
      meas_valid  <= valid_nx;
      locked      <= (state_nx == S_TRACK) && (match_nx == LOCK_W);
      no_signal   <= (state_nx != S_TRACK);
    end
  end

endmodule
